// File: rtl/led_status_arbiter_if.sv
// Request/status bundle between the status sources and the LED blink engine.
interface led_status_arbiter_if;
   logic [3:0]  req;
   logic [15:0] req_type;
   logic        led_en;
   logic [3:0]  blink_type;
   logic [3:0]  grant;
   logic        chg;
   logic        ms_tick;

   modport master (
      output req, req_type,
      input  led_en, blink_type, grant, chg, ms_tick
   );

   modport slave (
      input  req, req_type,
      output led_en, blink_type, grant, chg, ms_tick
   );
endinterface

// File: rtl/led_status_arbiter.sv
// Fixed-priority status arbiter: the granted source owns the LED pattern for at
// least MIN_HOLD_MS millisecond ticks before anything else can take it over.
module led_status_arbiter #(
   parameter int unsigned SYS_CLK_MHZ = 150,
   parameter logic [15:0] MIN_HOLD_MS = 16'd1000,
   parameter logic [3:0]  IDLE_TYPE   = 4'h0
) (
   input  logic clk,
   input  logic rst_n,
   led_status_arbiter_if.slave bus
);

   localparam logic [31:0] PRESCALE_MAX = 32'(SYS_CLK_MHZ * 1000 - 1);

   typedef enum logic {IDLE, SHOW} state_t;

   state_t      state, state_nx;
   logic [31:0] prescale;
   logic        ms_tick;
   logic [15:0] hold_cnt, hold_nx;
   logic [3:0]  grant, grant_nx;
   logic [3:0]  blink_type, blink_nx;
   logic        led_en, led_nx;
   logic        chg, chg_nx;
   logic [3:0]  top;
   logic [1:0]  top_idx;
   logic [3:0]  top_type;
   logic        expired;

   // Free-running millisecond prescaler; the tick is registered in the wrap cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale <= 32'd0;
         ms_tick  <= 1'b0;
      end else if (prescale == PRESCALE_MAX) begin
         prescale <= 32'd0;
         ms_tick  <= 1'b1;
      end else begin
         prescale <= prescale + 32'd1;
         ms_tick  <= 1'b0;
      end
   end

   always_comb begin
      top     = 4'b0000;
      top_idx = 2'd0;
      if (bus.req[3]) begin
         top     = 4'b1000;
         top_idx = 2'd3;
      end else if (bus.req[2]) begin
         top     = 4'b0100;
         top_idx = 2'd2;
      end else if (bus.req[1]) begin
         top     = 4'b0010;
         top_idx = 2'd1;
      end else if (bus.req[0]) begin
         top     = 4'b0001;
         top_idx = 2'd0;
      end
      top_type = bus.req_type[{top_idx, 2'b00} +: 4];
   end

   assign expired = (hold_cnt == 16'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hold_cnt   <= 16'd0;
         grant      <= 4'b0000;
         blink_type <= IDLE_TYPE;
         led_en     <= 1'b0;
         chg        <= 1'b0;
      end else begin
         state      <= state_nx;
         hold_cnt   <= hold_nx;
         grant      <= grant_nx;
         blink_type <= blink_nx;
         led_en     <= led_nx;
         chg        <= chg_nx;
      end
   end

   // Later assignments to hold_nx override the tick decrement, so a regrant reloads.
   always_comb begin
      state_nx = state;
      hold_nx  = hold_cnt;
      grant_nx = grant;
      blink_nx = blink_type;
      led_nx   = led_en;
      chg_nx   = 1'b0;

      unique case (state)
         IDLE: begin
            grant_nx = 4'b0000;
            blink_nx = IDLE_TYPE;
            led_nx   = 1'b0;
            if (bus.req != 4'b0000) begin
               state_nx = SHOW;
               grant_nx = top;
               blink_nx = top_type;
               led_nx   = 1'b1;
               hold_nx  = MIN_HOLD_MS;
               chg_nx   = 1'b1;
            end
         end
         SHOW: begin
            if (ms_tick && !expired) begin
               hold_nx = hold_cnt - 16'd1;
            end
            if (expired) begin
               if (bus.req == 4'b0000) begin
                  state_nx = IDLE;
                  grant_nx = 4'b0000;
                  blink_nx = IDLE_TYPE;
                  led_nx   = 1'b0;
                  hold_nx  = 16'd0;
                  chg_nx   = 1'b1;
               end else if (top != grant) begin
                  grant_nx = top;
                  blink_nx = top_type;
                  led_nx   = 1'b1;
                  hold_nx  = MIN_HOLD_MS;
                  chg_nx   = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.led_en     = led_en;
   assign bus.blink_type = blink_type;
   assign bus.grant      = grant;
   assign bus.chg        = chg;
   assign bus.ms_tick    = ms_tick;

endmodule

// File: tb/tb_led_status_arbiter.sv
// Directed bench for led_status_arbiter: expected outputs are queued when stimulus
// is applied and popped when the arbiter answers one clock later.
module tb_led_status_arbiter;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   led_status_arbiter_if bus ();

   led_status_arbiter #(
      .SYS_CLK_MHZ (1),
      .MIN_HOLD_MS (16'd2),
      .IDLE_TYPE   (4'h0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [3:0] grant;
      logic [3:0] blink;
      logic       led;
      logic       chg;
   } expect_t;

   expect_t scoreboard[$];

   task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [3:0] r, input logic [15:0] t);
      bus.req      = r;
      bus.req_type = t;
   endtask

   task automatic push_expect(input string tag, input logic [3:0] g, input logic [3:0] b,
                              input logic l, input logic c);
      expect_t e;
      e.tag   = tag;
      e.grant = g;
      e.blink = b;
      e.led   = l;
      e.chg   = c;
      scoreboard.push_back(e);
   endtask

   task automatic check_output();
      expect_t e;
      if (scoreboard.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         e = scoreboard.pop_front();
         check_value({e.tag, "_grant"}, 32'(bus.grant), 32'(e.grant));
         check_value({e.tag, "_blink"}, 32'(bus.blink_type), 32'(e.blink));
         check_value({e.tag, "_led"},   32'(bus.led_en), 32'(e.led));
         check_value({e.tag, "_chg"},   32'(bus.chg), 32'(e.chg));
      end
   endtask

   // Waits at negedges until grant leaves 'from'; elapsed counts negedges taken.
   task automatic wait_grant_change(input logic [3:0] from, input int budget, inout int elapsed);
      int n;
      n = 0;
      while (bus.grant === from && n < budget) begin
         @(negedge clk);
         n++;
         elapsed++;
      end
   endtask

   initial begin
      int elapsed;
      int gap;
      int chg_seen;

      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      apply_stimulus(4'b0000, 16'h3752);

      // Reset state
      repeat (3) @(negedge clk);
      push_expect("reset", 4'b0000, 4'h0, 1'b0, 1'b0);
      check_output();
      check_value("reset_ms_tick", 32'(bus.ms_tick), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] single source");
      apply_stimulus(4'b0001, 16'h3752);
      push_expect("single_grant", 4'b0001, 4'h2, 1'b1, 1'b1);
      @(negedge clk);
      check_output();
      @(negedge clk);
      check_value("single_chg_pulse", 32'(bus.chg), 32'd0);
      repeat (5000) @(negedge clk);
      check_value("single_held", 32'(bus.grant), 32'b0001);
      apply_stimulus(4'b0000, 16'h3752);
      push_expect("single_release", 4'b0000, 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      check_output();

      $display("[TB] ms_tick period");
      elapsed = 0;
      while (bus.ms_tick !== 1'b1 && elapsed < 1100) begin
         @(negedge clk);
         elapsed++;
      end
      check_value("tick_found", 32'(bus.ms_tick), 32'd1);
      for (int p = 0; p < 3; p++) begin
         gap = 0;
         do begin
            @(negedge clk);
            gap++;
         end while (bus.ms_tick !== 1'b1 && gap < 1100);
         check_value("tick_period", 32'(gap), 32'd1000);
      end

      $display("[TB] no preemption");
      apply_stimulus(4'b0001, 16'h3752);
      push_expect("nopre_grant", 4'b0001, 4'h2, 1'b1, 1'b1);
      @(negedge clk);
      check_output();
      elapsed = 0;
      repeat (100) begin
         @(negedge clk);
         elapsed++;
      end
      apply_stimulus(4'b1001, 16'h3752);
      repeat (5) begin
         @(negedge clk);
         elapsed++;
      end
      check_value("nopre_frozen", 32'(bus.grant), 32'b0001);
      wait_grant_change(4'b0001, 2200, elapsed);
      push_expect("nopre_regrant", 4'b1000, 4'h3, 1'b1, 1'b1);
      check_output();
      check_value("nopre_window", 32'(elapsed > 1000 && elapsed <= 2001), 32'd1);
      apply_stimulus(4'b0000, 16'h3752);
      elapsed = 0;
      wait_grant_change(4'b1000, 2200, elapsed);
      push_expect("nopre_idle", 4'b0000, 4'h0, 1'b0, 1'b1);
      check_output();

      $display("[TB] simultaneous requests");
      @(negedge clk);
      apply_stimulus(4'b0110, 16'h3752);
      push_expect("simul_grant", 4'b0100, 4'h7, 1'b1, 1'b1);
      @(negedge clk);
      check_output();

      $display("[TB] owner type change");
      apply_stimulus(4'b0110, 16'h3A52);
      chg_seen = 0;
      repeat (2100) begin
         @(negedge clk);
         if (bus.chg === 1'b1) chg_seen++;
      end
      check_value("owner_blink_kept", 32'(bus.blink_type), 32'h7);
      check_value("owner_grant_kept", 32'(bus.grant), 32'b0100);
      check_value("owner_no_chg", 32'(chg_seen), 32'd0);

      $display("[TB] fall-through");
      apply_stimulus(4'b0010, 16'h3A52);
      push_expect("fall_grant", 4'b0010, 4'h5, 1'b1, 1'b1);
      @(negedge clk);
      check_output();
      @(negedge clk);
      check_value("fall_chg_single", 32'(bus.chg), 32'd0);

      $display("[TB] reset mid-show");
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      push_expect("async_reset", 4'b0000, 4'h0, 1'b0, 1'b0);
      #1 check_output();
      @(negedge clk);
      rst_n = 1'b1;
      push_expect("post_reset_grant", 4'b0010, 4'h5, 1'b1, 1'b1);
      @(negedge clk);
      check_output();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
